// File: rtl/prei_blk8x8_act_pkg.sv
// Shared pre-intra definitions: datapath widths, LCU size and the block FSM encoding.
package prei_blk8x8_act_pkg;

    localparam int PIX_W           = 8;
    localparam int ROW_PIX         = 8;
    localparam int ROW_W           = ROW_PIX * PIX_W;
    localparam int BLK_W           = 8 * ROW_W;
    localparam int IDX_W           = 7;
    localparam int ROW_SUM_W       = PIX_W + 3;
    localparam int ROW_SQ_W        = 2 * PIX_W + 3;
    localparam int SUM_W           = PIX_W + 6;
    localparam int SUMSQ_W         = 2 * PIX_W + 6;
    localparam int MEAN_W          = PIX_W;
    localparam int VAR_W           = 16;
    localparam int LCU_SUM_W       = 20;
    localparam int CALC_W          = 28;
    localparam int VAR_SHIFT       = 12;
    localparam int DEF_BLK_PER_LCU = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [2*PIX_W-1:0] pix_sq(input logic [PIX_W-1:0] p);
        logic [2*PIX_W-1:0] pe;
        pe = {{PIX_W{1'b0}}, p};
        return pe * pe;
    endfunction

endpackage

// File: rtl/prei_blk8x8_act_row_sq8.sv
// Combinational row statistics: sum and sum-of-squares of eight pixels via a
// three-level adder tree. Pixel 0 of the row sits in the most significant byte.
module prei_row_sq8
    import prei_blk8x8_act_pkg::*;
(
    input  logic [ROW_W-1:0]     row_i,
    output logic [ROW_SUM_W-1:0] row_sum_o,
    output logic [ROW_SQ_W-1:0]  row_sq_o
);

    logic [PIX_W-1:0]     w_pix [ROW_PIX];
    logic [2*PIX_W-1:0]   w_sq  [ROW_PIX];
    logic [PIX_W:0]       w_s1  [4];
    logic [2*PIX_W:0]     w_q1  [4];
    logic [PIX_W+1:0]     w_s2  [2];
    logic [2*PIX_W+1:0]   w_q2  [2];

    // squarers and adder tree
    always_comb begin
        for (int i = 0; i < ROW_PIX; i++) begin
            w_pix[i] = row_i[ROW_W-1-PIX_W*i -: PIX_W];
            w_sq[i]  = pix_sq(w_pix[i]);
        end
        for (int i = 0; i < 4; i++) begin
            w_s1[i] = {1'b0, w_pix[2*i]} + {1'b0, w_pix[2*i+1]};
            w_q1[i] = {1'b0, w_sq[2*i]}  + {1'b0, w_sq[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            w_s2[i] = {1'b0, w_s1[2*i]} + {1'b0, w_s1[2*i+1]};
            w_q2[i] = {1'b0, w_q1[2*i]} + {1'b0, w_q1[2*i+1]};
        end
        row_sum_o = {1'b0, w_s2[0]} + {1'b0, w_s2[1]};
        row_sq_o  = {1'b0, w_q2[0]} + {1'b0, w_q2[1]};
    end

endmodule

// File: rtl/prei_blk8x8_act.sv
// 8x8 luma block activity: one row per cycle into sum/sumsq, then mean and variance,
// plus per-LCU minimum and total variance for the AQ / skip logic downstream.
module prei_blk8x8_act
    import prei_blk8x8_act_pkg::*;
#(
    parameter int BLK_PER_LCU = DEF_BLK_PER_LCU
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic [IDX_W-1:0]     blk_idx_i,
    input  logic [BLK_W-1:0]     blk_data_i,
    input  logic                 lcu_clr_i,
    output logic                 busy_o,
    output logic                 ovf_o,
    output logic                 done_o,
    output logic [IDX_W-1:0]     blk_idx_o,
    output logic [SUM_W-1:0]     sum_o,
    output logic [MEAN_W-1:0]    mean_o,
    output logic [VAR_W-1:0]     var_o,
    output logic                 lcu_done_o,
    output logic [VAR_W-1:0]     lcu_min_var_o,
    output logic [LCU_SUM_W-1:0] lcu_sum_var_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_PER_LCU - 1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   w_accept;
    logic [BLK_W-1:0]       r_shift;
    logic [IDX_W-1:0]       r_idx;
    logic [2:0]             r_row_cnt;
    logic [SUM_W-1:0]       r_sum;
    logic [SUMSQ_W-1:0]     r_sumsq;
    logic [ROW_SUM_W-1:0]   w_row_sum;
    logic [ROW_SQ_W-1:0]    w_row_sq;
    logic [CALC_W-1:0]      w_sumsq_x64;
    logic [CALC_W-1:0]      w_sum_sq;
    logic [CALC_W-1:0]      w_diff;
    logic [VAR_W-1:0]       w_var;
    logic                   w_is_last;
    logic [VAR_W-1:0]       w_lcu_min_nxt;
    logic [LCU_SUM_W-1:0]   w_lcu_sum_nxt;

    logic                   r_busy;
    logic                   r_ovf;
    logic                   r_done;
    logic [IDX_W-1:0]       r_blk_idx;
    logic [SUM_W-1:0]       r_sum_o;
    logic [MEAN_W-1:0]      r_mean;
    logic [VAR_W-1:0]       r_var;
    logic                   r_lcu_done;
    logic [VAR_W-1:0]       r_lcu_min;
    logic [LCU_SUM_W-1:0]   r_lcu_sum;
    logic                   r_lcu_first;
    logic                   r_lcu_wrap;

    prei_row_sq8 u_row_sq8 (
        .row_i     (r_shift[BLK_W-1 -: ROW_W]),
        .row_sum_o (w_row_sum),
        .row_sq_o  (w_row_sq)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_ACC;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (r_row_cnt == 3'd7) begin
                    w_state_nxt = ST_CALC;
                end else begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_CALC: w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // variance and LCU statistic candidates; 64*sumsq >= sum^2 always holds
    always_comb begin
        w_sumsq_x64   = {r_sumsq, 6'd0};
        w_sum_sq      = CALC_W'(r_sum) * CALC_W'(r_sum);
        w_diff        = w_sumsq_x64 - w_sum_sq;
        w_var         = VAR_W'(w_diff >> VAR_SHIFT);
        w_is_last     = (r_idx == LAST_IDX);
        w_lcu_min_nxt = r_lcu_min;
        w_lcu_sum_nxt = r_lcu_sum;
        if (r_lcu_first) begin
            w_lcu_min_nxt = w_var;
            w_lcu_sum_nxt = LCU_SUM_W'(w_var);
        end else begin
            w_lcu_min_nxt = (w_var < r_lcu_min) ? w_var : r_lcu_min;
            w_lcu_sum_nxt = r_lcu_sum + LCU_SUM_W'(w_var);
        end
    end

    // block capture and row accumulation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift   <= {BLK_W{1'b0}};
            r_idx     <= {IDX_W{1'b0}};
            r_row_cnt <= 3'd0;
            r_sum     <= {SUM_W{1'b0}};
            r_sumsq   <= {SUMSQ_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= blk_data_i;
                        r_idx     <= blk_idx_i;
                        r_row_cnt <= 3'd0;
                        r_sum     <= {SUM_W{1'b0}};
                        r_sumsq   <= {SUMSQ_W{1'b0}};
                    end
                end
                ST_ACC: begin
                    r_sum     <= r_sum + SUM_W'(w_row_sum);
                    r_sumsq   <= r_sumsq + SUMSQ_W'(w_row_sq);
                    r_shift   <= {r_shift[BLK_W-ROW_W-1:0], {ROW_W{1'b0}}};
                    r_row_cnt <= r_row_cnt + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // block result, busy and overflow registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_lcu_done <= 1'b0;
            r_blk_idx  <= {IDX_W{1'b0}};
            r_sum_o    <= {SUM_W{1'b0}};
            r_mean     <= {MEAN_W{1'b0}};
            r_var      <= {VAR_W{1'b0}};
        end else begin
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (r_state == ST_CALC);
            r_lcu_done <= (r_state == ST_CALC) && w_is_last;
            if (lcu_clr_i) begin
                r_ovf <= 1'b0;
            end else if (start_i && (r_state != ST_IDLE)) begin
                r_ovf <= 1'b1;
            end
            if (r_state == ST_CALC) begin
                r_blk_idx <= r_idx;
                r_sum_o   <= r_sum;
                r_mean    <= r_sum[SUM_W-1 -: MEAN_W];
                r_var     <= w_var;
            end
        end
    end

    // LCU accumulators; a clear beats the block update, and the first start after an
    // LCU summary restarts accumulation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lcu_min   <= {VAR_W{1'b0}};
            r_lcu_sum   <= {LCU_SUM_W{1'b0}};
            r_lcu_first <= 1'b1;
            r_lcu_wrap  <= 1'b0;
        end else if (lcu_clr_i) begin
            r_lcu_min   <= {VAR_W{1'b0}};
            r_lcu_sum   <= {LCU_SUM_W{1'b0}};
            r_lcu_first <= 1'b1;
            r_lcu_wrap  <= 1'b0;
        end else if (r_state == ST_CALC) begin
            r_lcu_min   <= w_lcu_min_nxt;
            r_lcu_sum   <= w_lcu_sum_nxt;
            r_lcu_first <= 1'b0;
            r_lcu_wrap  <= w_is_last;
        end else if (w_accept && r_lcu_wrap) begin
            r_lcu_first <= 1'b1;
            r_lcu_wrap  <= 1'b0;
        end
    end

    assign busy_o        = r_busy;
    assign ovf_o         = r_ovf;
    assign done_o        = r_done;
    assign blk_idx_o     = r_blk_idx;
    assign sum_o         = r_sum_o;
    assign mean_o        = r_mean;
    assign var_o         = r_var;
    assign lcu_done_o    = r_lcu_done;
    assign lcu_min_var_o = r_lcu_min;
    assign lcu_sum_var_o = r_lcu_sum;

endmodule

// File: tb/tb_prei_blk8x8_act.sv
// Self-checking bench for prei_blk8x8_act: a cycle-level behavioural model checked
// every cycle, directed literal cases, and randomized blocks, clears and collisions.
module tb_prei_blk8x8_act;

    localparam int BLK = 64;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start_i;
    logic [6:0]   blk_idx_i;
    logic [511:0] blk_data_i;
    logic         lcu_clr_i;
    logic         busy_o;
    logic         ovf_o;
    logic         done_o;
    logic [6:0]   blk_idx_o;
    logic [13:0]  sum_o;
    logic [7:0]   mean_o;
    logic [15:0]  var_o;
    logic         lcu_done_o;
    logic [15:0]  lcu_min_var_o;
    logic [19:0]  lcu_sum_var_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prei_blk8x8_act dut (
        .clk           (clk),
        .rstn          (rstn),
        .start_i       (start_i),
        .blk_idx_i     (blk_idx_i),
        .blk_data_i    (blk_data_i),
        .lcu_clr_i     (lcu_clr_i),
        .busy_o        (busy_o),
        .ovf_o         (ovf_o),
        .done_o        (done_o),
        .blk_idx_o     (blk_idx_o),
        .sum_o         (sum_o),
        .mean_o        (mean_o),
        .var_o         (var_o),
        .lcu_done_o    (lcu_done_o),
        .lcu_min_var_o (lcu_min_var_o),
        .lcu_sum_var_o (lcu_sum_var_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // pattern 0 flat 100, 1 checkerboard 0/255, 2 ramp x+8y, otherwise random
    function automatic logic [511:0] mk_blk(input int kind);
        logic [511:0] d;
        int pix;
        d = '0;
        for (int p = 0; p < 64; p++) begin
            case (kind)
                0:       pix = 100;
                1:       pix = (((p % 8) + (p / 8)) % 2 == 1) ? 255 : 0;
                2:       pix = p;
                default: pix = int'($urandom_range(0, 255));
            endcase
            d[511-8*p -: 8] = 8'(pix);
        end
        return d;
    endfunction

    function automatic int blk_sum(input logic [511:0] d);
        int s = 0;
        for (int p = 0; p < 64; p++) s += int'(d[511-8*p -: 8]);
        return s;
    endfunction

    function automatic int blk_var(input logic [511:0] d);
        longint s = 0;
        longint q = 0;
        longint v;
        for (int p = 0; p < 64; p++) begin
            s += longint'(d[511-8*p -: 8]);
            q += longint'(d[511-8*p -: 8]) * longint'(d[511-8*p -: 8]);
        end
        v = (64 * q - s * s) / 4096;
        return int'(v);
    endfunction

    // behavioural model: phase counts cycles since an accepted start (10 = done cycle)
    int   m_phase, p_idx, p_sum, p_var;
    int   m_idx, m_sum, m_mean, m_var, m_lmin, m_lsum;
    logic m_ovf, m_done, m_ldone, m_first, m_wrap;

    initial begin
        m_phase = 0; m_first = 1'b1; m_wrap = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_phase = 0; m_ovf = 1'b0; m_done = 1'b0; m_ldone = 1'b0;
                m_idx = 0; m_sum = 0; m_mean = 0; m_var = 0; m_lmin = 0; m_lsum = 0;
                m_first = 1'b1; m_wrap = 1'b0;
                p_idx = 0; p_sum = 0; p_var = 0;
            end else begin
                m_done  = 1'b0;
                m_ldone = 1'b0;
                if (m_phase == 0) begin
                    if (start_i) begin
                        m_phase = 1;
                        p_idx   = int'(blk_idx_i);
                        p_sum   = blk_sum(blk_data_i);
                        p_var   = blk_var(blk_data_i);
                        if (m_wrap) begin
                            m_first = 1'b1;
                            m_wrap  = 1'b0;
                        end
                    end
                end else begin
                    if (start_i) m_ovf = 1'b1;
                    m_phase = (m_phase == 10) ? 0 : m_phase + 1;
                end
                if (lcu_clr_i) m_ovf = 1'b0;
                if (m_phase == 10) begin
                    m_done  = 1'b1;
                    m_idx   = p_idx;
                    m_sum   = p_sum;
                    m_mean  = p_sum / 64;
                    m_var   = p_var;
                    m_ldone = (p_idx == BLK - 1);
                    if (!lcu_clr_i) begin
                        if (m_first) begin
                            m_lmin = p_var;
                            m_lsum = p_var;
                        end else begin
                            m_lmin = (p_var < m_lmin) ? p_var : m_lmin;
                            m_lsum = m_lsum + p_var;
                        end
                        m_first = 1'b0;
                        m_wrap  = m_ldone;
                    end
                end
                if (lcu_clr_i) begin
                    m_lmin = 0; m_lsum = 0; m_first = 1'b1; m_wrap = 1'b0;
                end
            end
            chk("busy", 32'(busy_o), 32'(m_phase != 0));
            chk("ovf", 32'(ovf_o), 32'(m_ovf));
            chk("done", 32'(done_o), 32'(m_done));
            chk("lcu_done", 32'(lcu_done_o), 32'(m_ldone));
            chk("blk_idx", 32'(blk_idx_o), 32'(m_idx));
            chk("sum", 32'(sum_o), 32'(m_sum));
            chk("mean", 32'(mean_o), 32'(m_mean));
            chk("var", 32'(var_o), 32'(m_var));
            chk("lcu_min", 32'(lcu_min_var_o), 32'(m_lmin));
            chk("lcu_sum", 32'(lcu_sum_var_o), 32'(m_lsum));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [511:0] d, input logic [6:0] idx);
        blk_data_i = d;
        blk_idx_i  = idx;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic pulse_clr();
        lcu_clr_i = 1'b1;
        tick();
        lcu_clr_i = 1'b0;
    endtask

    // one block with literal expectations; returns in the first cycle a new start is legal
    task automatic run_blk(input string nm, input int kind, input logic [6:0] idx,
                           input int es, input int em, input int ev, input logic eld);
        pulse_start(mk_blk(kind), idx);
        repeat (8) @(negedge clk);
        chk({nm, "_done_early"}, 32'(done_o), 32'd0);
        @(negedge clk);
        chk({nm, "_done"}, 32'(done_o), 32'd1);
        chk({nm, "_sum"}, 32'(sum_o), 32'(es));
        chk({nm, "_mean"}, 32'(mean_o), 32'(em));
        chk({nm, "_var"}, 32'(var_o), 32'(ev));
        chk({nm, "_idx"}, 32'(blk_idx_o), 32'(idx));
        chk({nm, "_lcu_done"}, 32'(lcu_done_o), 32'(eld));
        tick();
    endtask

    initial begin
        int kind;
        int idx;
        int gap;
        rstn = 1'b0; start_i = 1'b0; lcu_clr_i = 1'b0; blk_idx_i = 7'd0; blk_data_i = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_sum", 32'(sum_o), 32'd0);
        chk("rst_lcu_sum", 32'(lcu_sum_var_o), 32'd0);
        rstn = 1'b1;
        tick();

        run_blk("flat", 0, 7'd0, 6400, 100, 0, 1'b0);
        run_blk("checker", 1, 7'd1, 8160, 127, 16256, 1'b0);
        run_blk("ramp", 2, 7'd2, 2016, 31, 341, 1'b0);

        // collision at T+3
        pulse_clr();
        pulse_start(mk_blk(1), 7'd5);
        tick();
        tick();
        pulse_start(mk_blk(2), 7'd9);
        repeat (6) @(negedge clk);
        chk("coll_done", 32'(done_o), 32'd1);
        chk("coll_sum", 32'(sum_o), 32'd8160);
        chk("coll_var", 32'(var_o), 32'd16256);
        chk("coll_idx", 32'(blk_idx_o), 32'd5);
        chk("coll_ovf", 32'(ovf_o), 32'd1);
        tick();
        pulse_clr();
        chk("clr_ovf", 32'(ovf_o), 32'd0);
        chk("clr_lcu_min", 32'(lcu_min_var_o), 32'd0);
        chk("clr_lcu_sum", 32'(lcu_sum_var_o), 32'd0);

        // reset at T+5 aborts the block
        pulse_start(mk_blk(0), 7'd3);
        repeat (4) tick();
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_sum", 32'(sum_o), 32'd0);
        chk("midrst_var", 32'(var_o), 32'd0);
        #1;
        tick();
        rstn = 1'b1;
        tick();
        run_blk("flat_after_rst", 0, 7'd0, 6400, 100, 0, 1'b0);

        // full LCU: block 10 ramp, others checkerboard
        pulse_clr();
        for (int i = 0; i < BLK; i++) begin
            if (i == 10) run_blk("lcu_ramp", 2, 7'(i), 2016, 31, 341, 1'b0);
            else         run_blk("lcu_chk", 1, 7'(i), 8160, 127, 16256, i == BLK - 1);
        end
        chk("lcu_min_final", 32'(lcu_min_var_o), 32'd341);
        chk("lcu_sum_final", 32'(lcu_sum_var_o), 32'd1024469);

        run_blk("oor_idx", 2, 7'd100, 2016, 31, 341, 1'b0);
        chk("oor_lcu_min", 32'(lcu_min_var_o), 32'd341);
        chk("oor_lcu_sum", 32'(lcu_sum_var_o), 32'd341);

        // randomized blocks, gaps that sometimes collide, occasional clears
        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 3));
            idx  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : (i % BLK);
            gap  = int'($urandom_range(8, 13));
            pulse_start(mk_blk(kind), 7'(idx));
            repeat (gap) begin
                if ($urandom_range(0, 19) == 0) lcu_clr_i = 1'b1;
                tick();
                lcu_clr_i = 1'b0;
            end
        end
        repeat (15) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prei_blk8x8_act.md
Name: prei_blk8x8_act

Overview:
- Pre-intra stage directly downstream of the 8x8 original-pixel fetch.
- Accepts one 512-bit 8x8 luma block (64 x 8-bit pixels) per start pulse and computes the block sum, mean and variance (activity).
- Accumulates per-LCU activity statistics (minimum and total block variance) for the AQ / mode-decision-skip logic downstream.
- Processes one pixel row per cycle, so one small multiplier array serves all eight rows.

Parameters:
- BLK_PER_LCU, 64, number of 8x8 blocks per LCU; the LCU summary fires on block index BLK_PER_LCU-1.
- PIX_W, 8, pixel bit depth; widths below are stated for PIX_W=8.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; blk_data_i and blk_idx_i are valid in this cycle
- blk_idx_i  in  7  block index within LCU (0..BLK_PER_LCU-1)
- blk_data_i  in  512  pixel (x,y) at bits [511-8*(8y+x) -: 8]; row 0 is in the upper 256 bits
- lcu_clr_i  in  1  synchronous clear of LCU accumulators (tied to the fetch finish)
- busy_o  out  1  block in progress; start_i ignored while high
- ovf_o  out  1  sticky: start_i arrived while busy; cleared by lcu_clr_i
- done_o  out  1  one-cycle pulse; block results valid
- blk_idx_o  out  7  index of the completed block
- sum_o  out  14  sum of 64 pixels
- mean_o  out  8  sum_o >> 6 (floor)
- var_o  out  16  (64*sumsq - sum^2) >> 12
- lcu_done_o  out  1  pulse coincident with done_o of block BLK_PER_LCU-1
- lcu_min_var_o  out  16  min var_o over the LCU
- lcu_sum_var_o  out  20  sum of var_o over the LCU

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; accumulators are cleared. Reset asserted mid-block aborts the block with no done_o.
- FSM states:
  - IDLE: start_i captures blk_data_i into a 512-bit shift register, latches blk_idx_i, clears the row counter, sum and sumsq, then moves to ACC.
  - ACC: 8 cycles, row counter 0..7. Each cycle adds the top row's 8 pixels to sum (14b) and their squares to sumsq (22b), then shifts the register left by 64. Leaves ACC when the counter reaches 7.
  - CALC: 1 cycle. Computes var = ((sumsq<<6) - sum*sum) >> 12 using 28-bit intermediates. The difference is never negative. Also updates the LCU min/sum.
  - DONE: 1 cycle. done_o is high; results are registered and held until the next DONE. Returns to IDLE.
- Latency: start_i in cycle T gives done_o in cycle T+10. busy_o is high T+1..T+10. The earliest next accepted start is T+11.
- start_i when not IDLE: ignored, ovf_o is set, and in-flight results are unaffected.
- LCU statistics:
  - First block after a clear: min = var.
  - Later blocks: min = min(min, var) and sum += var. The 20-bit sum cannot overflow for 64 blocks.
  - lcu_done_o pulses in DONE when blk_idx == BLK_PER_LCU-1. The LCU outputs update in the same cycle as the block outputs.
  - The accumulators auto-reset at the next start after lcu_done_o.
- lcu_clr_i together with DONE: the clear wins for the accumulators, but the block outputs still update and done_o still pulses.
- Out-of-range blk_idx_i (>= BLK_PER_LCU): the block is processed normally but never triggers lcu_done_o.

Decomposition:
- Shared pre-intra package holds:
  - pixel, sum, sumsq and var width constants;
  - BLK_PER_LCU default;
  - the FSM state encoding (IDLE/ACC/CALC/DONE, 2 bits).
- One natural sub-module: prei_row_sq8. It is combinational; it takes 64-bit row in and returns an 11-bit row sum and an 19-bit row sum-of-squares. Eight 8x8 squarers feed an adder tree, and it is reusable by later SAD/SATD stages.

Test Plan:
- Flat block: all pixels 100, idx 0 → done at T+10; sum_o=6400, mean_o=100, var_o=0, lcu_done_o=0.
- Checkerboard: alternating 0/255 → sum_o=8160, mean_o=127, var_o=16256.
- Ramp: pixel = x+8y → sum_o=2016, mean_o=31, var_o=341.
- Full LCU:
  - Stimulus: 64 blocks; block 10 is the ramp, all others are the checkerboard.
  - Response: lcu_done_o pulses only with blk_idx_o=63; lcu_min_var_o=341; lcu_sum_var_o=63*16256+341=1024469.
- Collision: start_i again at T+3 → ignored, ovf_o=1, first block results unchanged. Then lcu_clr_i → ovf_o=0 and accumulators cleared.
- Reset mid-block: rstn low at T+5 → all outputs 0 and no done_o. A new start after release gives the correct flat-block result.
